oric_ram_arbiter: RTL



---
 rtl/oric_ram_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/oric_ram_arbiter.sv
// Single-port main-RAM arbiter: power-up/requested fill, fixed CPU slot, valid/ready loader.
// Optional loader checksum output ld_sum when ORIC_RAM_ARB_LDSUM_EN is defined.
module oric_ram_arbiter #(
  parameter int          ADDR_W     = 16,
  parameter logic [7:0]  FILL_VALUE = 8'h01
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clear_req,
  input  logic              cpu_slot,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we,
  output logic [7:0]        cpu_q,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  input  logic [7:0]        ram_q,
`ifdef ORIC_RAM_ARB_LDSUM_EN
  output logic [7:0]        ld_sum,
`endif
  output logic              clearing,
  output logic              clear_done
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic              we_nxt;
  logic              done_nxt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ram_addr   <= addr_nxt;
      ram_data   <= data_nxt;
      ram_we     <= we_nxt;
      clear_done <= done_nxt;
    end
  end

  // Idle cycles keep the last address/data on the RAM pins; only the write strobe drops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = ram_addr;
    data_nxt  = ram_data;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    ld_ready  = 1'b0;
    case (state)
      CLEAR: begin
        if (clear_req) begin
          cnt_nxt = '0;
        end else begin
          addr_nxt = cnt;
          data_nxt = FILL_VALUE;
          we_nxt   = 1'b1;
          cnt_nxt  = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (cpu_slot) begin
          addr_nxt = cpu_addr;
          data_nxt = cpu_din;
          we_nxt   = cpu_we;
        end else if (ld_valid) begin
          ld_ready = 1'b1;
          addr_nxt = ld_addr;
          data_nxt = ld_data;
          we_nxt   = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign clearing = (state == CLEAR);
  assign cpu_q    = ram_q;

`ifdef ORIC_RAM_ARB_LDSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                ld_sum <= '0;
    else if (clear_req)          ld_sum <= '0;
    else if (ld_valid && ld_ready) ld_sum <= ld_sum + ld_data;
  end
`endif

endmodule
